// File: rtl/mtr_pwm_pkg.sv
// mtr_pwm_pkg: types and constants shared by the motor PWM driver.
//   gate_state_t : gate FSM states (both-off, dead bands, one gate on)
//   PWM_W        : carrier counter / duty width (2048-clock period)
//   DEAD_DEF     : default dead time in clocks
package mtr_pwm_pkg;

    localparam int PWM_W    = 11;
    localparam int DEAD_DEF = 32;

    typedef enum logic [2:0] {
        OFF,
        DEAD_H,
        ON_H,
        DEAD_L,
        ON_L
    } gate_state_t;

endpackage

// File: rtl/mtr_pwm_drv_pwm11.sv
// pwm11: free-running 11-bit PWM carrier with a period-synchronous duty shadow.
//   clk, rst_n : clock, asynchronous active-low reset
//   duty_in    : requested duty, sampled only at the end of a period
//   pwm_synch  : one-clock pulse while the carrier sits at its last count
//   pwm_raw    : registered (cnt < duty_cur), lags the carrier by one clock
//   duty_cur   : duty in effect for the current period
module pwm11
    import mtr_pwm_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [PWM_W-1:0] duty_in,
    output logic             pwm_synch,
    output logic             pwm_raw,
    output logic [PWM_W-1:0] duty_cur
);

    // Raising the pulse one count early makes it coincide with cnt == 7FF.
    localparam logic [PWM_W-1:0] SYNCH_PRE = 11'h7FE;

    logic [PWM_W-1:0] cnt_q,   cnt_d;
    logic             synch_q, synch_d;
    logic [PWM_W-1:0] duty_q,  duty_d;
    logic             raw_q,   raw_d;

    // The shadow loads on the pulse clock, so a new duty starts exactly at cnt == 0.
    always_comb begin
        cnt_d   = cnt_q + 1'b1;
        synch_d = (cnt_q == SYNCH_PRE);
        duty_d  = synch_q ? duty_in : duty_q;
        raw_d   = (cnt_q < duty_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            synch_q <= 1'b0;
            duty_q  <= '0;
            raw_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            synch_q <= synch_d;
            duty_q  <= duty_d;
            raw_q   <= raw_d;
        end
    end

    assign pwm_synch = synch_q;
    assign pwm_raw   = raw_q;
    assign duty_cur  = duty_q;

endmodule

// File: rtl/mtr_pwm_drv.sv
// mtr_pwm_drv: PWM gate driver with dead-time insertion for one half bridge.
//   clk, rst_n : clock, asynchronous active-low reset
//   drv_mag    : 12-bit unsigned effort; the upper 11 bits become the duty
//   en         : drive enable, low forces both gates off on the next edge
//   high_side  : high-side gate (registered)
//   low_side   : low-side gate (registered)
//   PWM_synch  : one-clock pulse at the end of every 2048-clock period
//   duty_cur   : duty currently in effect
module mtr_pwm_drv
    import mtr_pwm_pkg::*;
#(
    parameter int unsigned DEAD = DEAD_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [11:0]      drv_mag,
    input  logic             en,
    output logic             high_side,
    output logic             low_side,
    output logic             PWM_synch,
    output logic [PWM_W-1:0] duty_cur
);

    localparam logic [7:0] DEAD_LAST = 8'(DEAD - 1);

    logic        pwm_raw;
    logic        drv_lsb_unused;

    gate_state_t state_q, state_d;
    logic [7:0]  dcnt_q,  dcnt_d;
    logic        high_q,  high_d;
    logic        low_q,   low_d;

    // The effort LSB is below the duty resolution.
    assign drv_lsb_unused = drv_mag[0];

    pwm11 u_pwm (
        .clk      (clk),
        .rst_n    (rst_n),
        .duty_in  (drv_mag[11:1]),
        .pwm_synch(PWM_synch),
        .pwm_raw  (pwm_raw),
        .duty_cur (duty_cur)
    );

    // Any level change of pwm_raw during a dead band restarts the opposite
    // dead band, so pulses shorter than DEAD never turn a gate on.
    always_comb begin
        state_d = state_q;
        dcnt_d  = dcnt_q;
        if (!en) begin
            state_d = OFF;
            dcnt_d  = '0;
        end else begin
            case (state_q)
                OFF: begin
                    state_d = pwm_raw ? DEAD_H : DEAD_L;
                    dcnt_d  = '0;
                end
                DEAD_H: begin
                    if (!pwm_raw) begin
                        state_d = DEAD_L;
                        dcnt_d  = '0;
                    end else if (dcnt_q == DEAD_LAST) begin
                        state_d = ON_H;
                        dcnt_d  = '0;
                    end else begin
                        dcnt_d = dcnt_q + 8'd1;
                    end
                end
                ON_H: begin
                    if (!pwm_raw) begin
                        state_d = DEAD_L;
                        dcnt_d  = '0;
                    end
                end
                DEAD_L: begin
                    if (pwm_raw) begin
                        state_d = DEAD_H;
                        dcnt_d  = '0;
                    end else if (dcnt_q == DEAD_LAST) begin
                        state_d = ON_L;
                        dcnt_d  = '0;
                    end else begin
                        dcnt_d = dcnt_q + 8'd1;
                    end
                end
                ON_L: begin
                    if (pwm_raw) begin
                        state_d = DEAD_H;
                        dcnt_d  = '0;
                    end
                end
                default: begin
                    state_d = OFF;
                    dcnt_d  = '0;
                end
            endcase
        end
        // Gates are registered from the next state so they change with it, glitch-free.
        high_d = (state_d == ON_H);
        low_d  = (state_d == ON_L);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= OFF;
            dcnt_q  <= '0;
            high_q  <= 1'b0;
            low_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dcnt_q  <= dcnt_d;
            high_q  <= high_d;
            low_q   <= low_d;
        end
    end

    assign high_side = high_q;
    assign low_side  = low_q;

endmodule

// File: tb/tb_mtr_pwm_drv.sv
// tb_mtr_pwm_drv: randomized and directed checks of mtr_pwm_drv against a
// cycle-indexed reference: carrier = cycles since reset mod 2048, duty taken
// at each period end, and a gate is on once en and the matching PWM level
// have both held for the last DEAD+1 clocks.
module tb_mtr_pwm_drv;

    localparam int DEAD = 32;
    localparam int PER  = 2048;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] drv_mag = 12'h000;
    logic        en = 1'b0;
    logic        high_side;
    logic        low_side;
    logic        PWM_synch;
    logic [10:0] duty_cur;

    int n_checks = 0;
    int n_fail   = 0;

    int          m_n;
    int          m_run_h;
    int          m_run_l;
    logic        m_pwm;
    logic [10:0] m_duty;

    mtr_pwm_drv #(.DEAD(DEAD)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .drv_mag  (drv_mag),
        .en       (en),
        .high_side(high_side),
        .low_side (low_side),
        .PWM_synch(PWM_synch),
        .duty_cur (duty_cur)
    );

    always #10 clk = ~clk;

    task automatic model_reset();
        m_n     = 0;
        m_run_h = 0;
        m_run_l = 0;
        m_pwm   = 1'b0;
        m_duty  = '0;
    endtask

    function automatic logic [13:0] model_expect();
        return {m_run_h >= DEAD + 1, m_run_l >= DEAD + 1, (m_n % PER) == PER - 1, m_duty};
    endfunction

    // One clock edge; the reference advances with the inputs seen at that edge.
    task automatic tick();
        logic new_pwm;
        @(posedge clk);
        new_pwm = ((m_n % PER) < int'(m_duty));
        if ((m_n % PER) == PER - 1) m_duty = drv_mag[11:1];
        m_run_h = (en && m_pwm)  ? m_run_h + 1 : 0;
        m_run_l = (en && !m_pwm) ? m_run_l + 1 : 0;
        m_pwm   = new_pwm;
        m_n++;
        #1;
    endtask

    task automatic test_reset();
        #1;
        n_checks++;
        if ({high_side, low_side, PWM_synch, duty_cur} !== 14'h0) begin
            n_fail++;
            $display("[TB] FAIL reset_state got=%h exp=0000", {high_side, low_side, PWM_synch, duty_cur});
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            n_checks++;
            if ({high_side, low_side, PWM_synch, duty_cur} !== model_expect()) begin
                n_fail++;
                $display("[TB] FAIL reset_idle cyc=%0d got=%h exp=%h", m_n, {high_side, low_side, PWM_synch, duty_cur}, model_expect());
            end
        end
    endtask

    task automatic test_half_duty();
        int syn = 0, hi = 0, lo = 0, both = 0, gap = 0;
        drv_mag = 12'h800;
        en      = 1'b1;
        for (int i = 0; i < 4 * PER + 64 && syn < 3; i++) begin
            tick();
            n_checks++;
            if ({high_side, low_side, PWM_synch, duty_cur} !== model_expect()) begin
                n_fail++;
                $display("[TB] FAIL half_duty cyc=%0d got=%h exp=%h", m_n, {high_side, low_side, PWM_synch, duty_cur}, model_expect());
            end
            if (syn == 2) begin
                hi   += int'(high_side);
                lo   += int'(low_side);
                both += int'(high_side & low_side);
                gap++;
            end
            if (PWM_synch) syn++;
        end
        n_checks += 4;
        if (syn != 3)    begin n_fail++; $display("[TB] FAIL half_synch_timeout got=%0d exp=3", syn); end
        if (gap != PER)  begin n_fail++; $display("[TB] FAIL synch_period got=%0d exp=%0d", gap, PER); end
        if (hi != 992)   begin n_fail++; $display("[TB] FAIL half_high_clocks got=%0d exp=992", hi); end
        if (lo != 992)   begin n_fail++; $display("[TB] FAIL half_low_clocks got=%0d exp=992", lo); end
        n_checks++;
        if (both != 0)   begin n_fail++; $display("[TB] FAIL gate_overlap got=%0d exp=0", both); end
    endtask

    task automatic test_extremes();
        logic [11:0] mags [2] = '{12'h000, 12'hFFF};
        int          lo_exp [2] = '{PER, 0};
        for (int v = 0; v < 2; v++) begin
            int syn = 0, hi = 0, lo = 0;
            drv_mag = mags[v];
            for (int i = 0; i < 4 * PER + 64 && syn < 3; i++) begin
                tick();
                n_checks++;
                if ({high_side, low_side, PWM_synch, duty_cur} !== model_expect()) begin
                    n_fail++;
                    $display("[TB] FAIL extreme_%h cyc=%0d got=%h exp=%h", mags[v], m_n, {high_side, low_side, PWM_synch, duty_cur}, model_expect());
                end
                if (syn == 2) begin
                    hi += int'(high_side);
                    lo += int'(low_side);
                end
                if (PWM_synch) syn++;
            end
            n_checks += 2;
            if (syn != 3)        begin n_fail++; $display("[TB] FAIL extreme_timeout got=%0d exp=3", syn); end
            if (lo != lo_exp[v]) begin n_fail++; $display("[TB] FAIL extreme_low_%h got=%0d exp=%0d", mags[v], lo, lo_exp[v]); end
            if (v == 0) begin
                n_checks++;
                if (hi != 0) begin n_fail++; $display("[TB] FAIL zero_high got=%0d exp=0", hi); end
            end
        end
    endtask

    task automatic test_shadow();
        int  hi = 0;
        bit  seen = 0;
        drv_mag = 12'h400;
        for (int i = 0; i < PER + 8 && !seen; i++) begin
            tick();
            n_checks++;
            if ({high_side, low_side, PWM_synch, duty_cur} !== model_expect()) begin
                n_fail++;
                $display("[TB] FAIL shadow_pre cyc=%0d got=%h exp=%h", m_n, {high_side, low_side, PWM_synch, duty_cur}, model_expect());
            end
            seen = PWM_synch;
        end
        for (int i = 0; i < 101; i++) begin
            tick();
            n_checks++;
            if ({high_side, low_side, PWM_synch, duty_cur} !== model_expect()) begin
                n_fail++;
                $display("[TB] FAIL shadow_lead cyc=%0d got=%h exp=%h", m_n, {high_side, low_side, PWM_synch, duty_cur}, model_expect());
            end
        end
        drv_mag = 12'hC00;
        seen = 0;
        for (int i = 0; i < PER + 8 && !seen; i++) begin
            tick();
            n_checks++;
            if ({high_side, low_side, PWM_synch, duty_cur} !== model_expect()) begin
                n_fail++;
                $display("[TB] FAIL shadow_hold cyc=%0d got=%h exp=%h", m_n, {high_side, low_side, PWM_synch, duty_cur}, model_expect());
            end
            seen = PWM_synch;
        end
        n_checks += 2;
        if (!seen)            begin n_fail++; $display("[TB] FAIL shadow_timeout got=0 exp=1"); end
        if (duty_cur != 512)  begin n_fail++; $display("[TB] FAIL shadow_old_duty got=%0d exp=512", duty_cur); end
        seen = 0;
        for (int i = 0; i < PER + 8 && !seen; i++) begin
            tick();
            n_checks++;
            if ({high_side, low_side, PWM_synch, duty_cur} !== model_expect()) begin
                n_fail++;
                $display("[TB] FAIL shadow_new cyc=%0d got=%h exp=%h", m_n, {high_side, low_side, PWM_synch, duty_cur}, model_expect());
            end
            if (i == 0) begin
                n_checks++;
                if (duty_cur != 1536) begin n_fail++; $display("[TB] FAIL shadow_new_duty got=%0d exp=1536", duty_cur); end
            end
            hi  += int'(high_side);
            seen = PWM_synch;
        end
        n_checks++;
        if (hi != 1504) begin n_fail++; $display("[TB] FAIL shadow_high_clocks got=%0d exp=1504", hi); end
    endtask

    task automatic test_narrow();
        int syn = 0, hi = 0, lo = 0;
        drv_mag = 12'h00A;
        for (int i = 0; i < 4 * PER + 64 && syn < 3; i++) begin
            tick();
            n_checks++;
            if ({high_side, low_side, PWM_synch, duty_cur} !== model_expect()) begin
                n_fail++;
                $display("[TB] FAIL narrow cyc=%0d got=%h exp=%h", m_n, {high_side, low_side, PWM_synch, duty_cur}, model_expect());
            end
            if (syn == 2) begin
                hi += int'(high_side);
                lo += int'(low_side);
            end
            if (PWM_synch) syn++;
        end
        n_checks += 3;
        if (syn != 3)           begin n_fail++; $display("[TB] FAIL narrow_timeout got=%0d exp=3", syn); end
        if (hi != 0)            begin n_fail++; $display("[TB] FAIL narrow_high got=%0d exp=0", hi); end
        if (lo != PER - 5 - DEAD) begin n_fail++; $display("[TB] FAIL narrow_low got=%0d exp=%0d", lo, PER - 5 - DEAD); end
    endtask

    task automatic test_enable();
        bit found = 0;
        int k = 0;
        drv_mag = 12'h800;
        en      = 1'b1;
        for (int i = 0; i < 3 * PER && !found; i++) begin
            tick();
            n_checks++;
            if ({high_side, low_side, PWM_synch, duty_cur} !== model_expect()) begin
                n_fail++;
                $display("[TB] FAIL enable_seek cyc=%0d got=%h exp=%h", m_n, {high_side, low_side, PWM_synch, duty_cur}, model_expect());
            end
            found = high_side;
        end
        n_checks++;
        if (!found) begin n_fail++; $display("[TB] FAIL enable_no_high got=0 exp=1"); end
        en = 1'b0;
        tick();
        n_checks++;
        if ({high_side, low_side} !== 2'b00) begin
            n_fail++;
            $display("[TB] FAIL enable_off got=%b exp=00", {high_side, low_side});
        end
        found = 0;
        for (int i = 0; i < PER + 8 && !found; i++) begin
            tick();
            n_checks++;
            if ({high_side, low_side, PWM_synch, duty_cur} !== model_expect()) begin
                n_fail++;
                $display("[TB] FAIL enable_idle cyc=%0d got=%h exp=%h", m_n, {high_side, low_side, PWM_synch, duty_cur}, model_expect());
            end
            found = PWM_synch;
        end
        for (int i = 0; i < 200; i++) tick();
        en    = 1'b1;
        found = 0;
        while (k < 100 && !found) begin
            tick();
            k++;
            n_checks++;
            if ({high_side, low_side, PWM_synch, duty_cur} !== model_expect()) begin
                n_fail++;
                $display("[TB] FAIL enable_on cyc=%0d got=%h exp=%h", m_n, {high_side, low_side, PWM_synch, duty_cur}, model_expect());
            end
            found = high_side;
        end
        n_checks++;
        if (k != DEAD + 1) begin n_fail++; $display("[TB] FAIL enable_latency got=%0d exp=%0d", k, DEAD + 1); end
    endtask

    task automatic test_async_reset();
        bit found = 0;
        int k = 0;
        drv_mag = 12'h800;
        en      = 1'b1;
        for (int i = 0; i < 3 * PER && !found; i++) begin
            tick();
            found = high_side | low_side;
        end
        #3;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({high_side, low_side, PWM_synch, duty_cur} !== 14'h0) begin
            n_fail++;
            $display("[TB] FAIL async_reset got=%h exp=0000", {high_side, low_side, PWM_synch, duty_cur});
        end
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        found = 0;
        while (k < PER + 8 && !found) begin
            tick();
            k++;
            n_checks++;
            if ({high_side, low_side, PWM_synch, duty_cur} !== model_expect()) begin
                n_fail++;
                $display("[TB] FAIL post_reset cyc=%0d got=%h exp=%h", m_n, {high_side, low_side, PWM_synch, duty_cur}, model_expect());
            end
            found = PWM_synch;
        end
        n_checks += 2;
        if (k != PER - 1)  begin n_fail++; $display("[TB] FAIL first_synch_edge got=%0d exp=%0d", k, PER - 1); end
        if (duty_cur != 0) begin n_fail++; $display("[TB] FAIL first_synch_duty got=%0d exp=0", duty_cur); end
        tick();
        n_checks++;
        if (duty_cur != 1024) begin n_fail++; $display("[TB] FAIL reload_duty got=%0d exp=1024", duty_cur); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 12000; i++) begin
            tick();
            n_checks++;
            if ({high_side, low_side, PWM_synch, duty_cur} !== model_expect()) begin
                n_fail++;
                $display("[TB] FAIL random cyc=%0d got=%h exp=%h", m_n, {high_side, low_side, PWM_synch, duty_cur}, model_expect());
            end
            if ($urandom_range(0, 699) == 0) drv_mag = 12'($urandom_range(0, 4095));
            if ($urandom_range(0, 899) == 0) en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 3999) == 0) begin
                #3;
                rst_n = 1'b0;
                #1;
                n_checks++;
                if ({high_side, low_side, PWM_synch, duty_cur} !== 14'h0) begin
                    n_fail++;
                    $display("[TB] FAIL random_reset got=%h exp=0000", {high_side, low_side, PWM_synch, duty_cur});
                end
                model_reset();
                @(negedge clk);
                rst_n = 1'b1;
            end
        end
    endtask

    initial begin
        $display("[TB] mtr_pwm_drv bench start");
        test_reset();
        test_half_duty();
        test_extremes();
        test_shadow();
        test_narrow();
        test_enable();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
